// File: rtl/mmio_responder.sv
// mmio_responder
//    Memory-mapped responder on the MIPS data-memory port. Decodes a
//    256-byte window at BASE_ADDR and serves five word registers:
//       0x00 DATA    store pushes a byte into the output FIFO, load returns 0
//       0x04 STATUS  {expired, ovf, full, empty, count}; store is W1C
//       0x08 RELOAD  timer reload value; a store also loads the counter
//       0x0C COUNT   current timer count (read-only)
//       0x10 CTRL    {irq_en, timer_en}
//    Any other in-window offset reads as 0 and ignores stores.
//
// Ports
//    Clk, reset            clock, synchronous active-high reset
//    req, Address, wr,     CPU access strobe, byte address, store flag and
//    WriteData             store data (all valid in the req cycle)
//    ReadData, ReadValid   registered load response, one cycle after req
//    out_data, out_valid,  FIFO head byte and valid; the consumer pops it
//    out_ready             by holding out_ready while out_valid is high
//    irq                   irq_en & expired
module mmio_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] Address,
   input  logic        wr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        ReadValid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // word offsets (Address[7:2])
   localparam logic [5:0] OFF_DATA   = 6'h00;
   localparam logic [5:0] OFF_STATUS = 6'h01;
   localparam logic [5:0] OFF_RELOAD = 6'h02;
   localparam logic [5:0] OFF_COUNT  = 6'h03;
   localparam logic [5:0] OFF_CTRL   = 6'h04;

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic          ovf_q, ovf_d;

   logic [31:0]   reload_q, reload_d;
   logic [31:0]   tcnt_q, tcnt_d;
   logic          expired_q, expired_d;
   logic          timer_en_q, timer_en_d;
   logic          irq_en_q, irq_en_d;

   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;

   // ---------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------
   logic       hit, wr_hit, rd_hit;
   logic [5:0] word;
   logic       unused_addr;

   assign hit         = req && (Address[31:8] == BASE_ADDR[31:8]);
   assign wr_hit      = hit && wr;
   assign rd_hit      = hit && !wr;
   assign word        = Address[7:2];
   assign unused_addr = ^Address[1:0];

   logic data_wr, status_wr, reload_wr, ctrl_wr;

   assign data_wr   = wr_hit && (word == OFF_DATA);
   assign status_wr = wr_hit && (word == OFF_STATUS);
   assign reload_wr = wr_hit && (word == OFF_RELOAD);
   assign ctrl_wr   = wr_hit && (word == OFF_CTRL);

   // ---------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------
   logic full, empty, pop, push, ovf_set;

   assign full  = (fcnt_q == CW'(FIFO_DEPTH));
   assign empty = (fcnt_q == '0);
   assign pop   = !empty && out_ready;
   // a pop in the same cycle frees a slot, so a full FIFO still accepts
   assign push    = data_wr && (!full || pop);
   assign ovf_set = data_wr && full && !pop;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fcnt_d   = fcnt_q;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
      // hardware set takes priority over the W1C clear
      ovf_d = ovf_set || (ovf_q && !(status_wr && WriteData[5]));
   end

   // ---------------------------------------------------------------
   // Timer
   // ---------------------------------------------------------------
   logic tick_en, expire;

   assign tick_en = timer_en_q && (tcnt_q != '0);
   assign expire  = tick_en && (tcnt_q == 32'd1);

   always_comb begin
      reload_d = reload_q;
      tcnt_d   = tcnt_q;
      if (reload_wr) begin
         // a software reload overrides a coinciding expiry
         reload_d = WriteData;
         tcnt_d   = WriteData;
      end else if (expire) begin
         tcnt_d = reload_q;   // reload 0 leaves the timer parked at 0
      end else if (tick_en) begin
         tcnt_d = tcnt_q - 32'd1;
      end
      expired_d  = (expire && !reload_wr) ||
                   (expired_q && !(status_wr && WriteData[6]));
      timer_en_d = ctrl_wr ? WriteData[0] : timer_en_q;
      irq_en_d   = ctrl_wr ? WriteData[1] : irq_en_q;
   end

   // ---------------------------------------------------------------
   // Read mux: registers as they stand before this cycle's updates
   // ---------------------------------------------------------------
   logic [31:0] status_w;

   assign status_w = 32'({expired_q, ovf_q, full, empty, fcnt_q});

   always_comb begin
      rdata_d  = '0;
      rvalid_d = rd_hit;
      if (rd_hit) begin
         case (word)
            OFF_STATUS: rdata_d = status_w;
            OFF_RELOAD: rdata_d = reload_q;
            OFF_COUNT:  rdata_d = tcnt_q;
            OFF_CTRL:   rdata_d = {30'b0, irq_en_q, timer_en_q};
            default:    rdata_d = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sequential
   // ---------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fcnt_q     <= '0;
         ovf_q      <= 1'b0;
         reload_q   <= '0;
         tcnt_q     <= '0;
         expired_q  <= 1'b0;
         timer_en_q <= 1'b0;
         irq_en_q   <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= WriteData[7:0];
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fcnt_q     <= fcnt_d;
         ovf_q      <= ovf_d;
         reload_q   <= reload_d;
         tcnt_q     <= tcnt_d;
         expired_q  <= expired_d;
         timer_en_q <= timer_en_d;
         irq_en_q   <= irq_en_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign ReadData  = rdata_q;
   assign ReadValid = rvalid_q;
   assign out_data  = mem_q[rd_ptr_q];
   assign out_valid = !empty;
   assign irq       = irq_en_q && expired_q;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder
//    Directed stimulus with a scoreboard: loads push their expected data
//    onto rq, bytes stored to DATA push onto bq; a monitor on the falling
//    edge pops and compares whenever ReadValid or a FIFO handshake occurs.
module tb_mmio_responder;

   localparam logic [31:0] A_DATA   = 32'hFFFF_FF00;
   localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
   localparam logic [31:0] A_RELOAD = 32'hFFFF_FF08;
   localparam logic [31:0] A_COUNT  = 32'hFFFF_FF0C;
   localparam logic [31:0] A_CTRL   = 32'hFFFF_FF10;
   localparam logic [31:0] A_UNMAP  = 32'hFFFF_FF20;

   logic        Clk = 1'b0;
   logic        reset, req, wr, out_ready;
   logic [31:0] Address, WriteData, ReadData;
   logic        ReadValid, out_valid, irq;
   logic [7:0]  out_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] rq [$];
   logic [7:0]  bq [$];

   mmio_responder dut (
      .Clk       (Clk),
      .reset     (reset),
      .req       (req),
      .Address   (Address),
      .wr        (wr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .ReadValid (ReadValid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .irq       (irq)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge Clk) begin
      if (ReadValid === 1'b1) begin
         if (rq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got ReadValid=1 data %h expected no response", ReadData);
         end else begin
            logic [31:0] e;
            e = rq.pop_front();
            chk("rd_data", ReadData, e);
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (bq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_unexpected: got %h expected no byte", out_data);
         end else begin
            logic [7:0] b;
            b = bq.pop_front();
            chk("out_byte", {24'b0, out_data}, {24'b0, b});
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; wr = 1'b1; Address = a; WriteData = d;
      tick();
      req = 1'b0; wr = 1'b0;
   endtask

   task automatic ld(input logic [31:0] a, input logic [31:0] exp);
      rq.push_back(exp);
      req = 1'b1; wr = 1'b0; Address = a;
      tick();
      req = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      out_ready = 1'b1;
      while (out_valid && k < 20) begin
         tick();
         k++;
      end
      chk("drain_empty", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; wr = 1'b0; Address = '0; WriteData = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // reset state
      chk("rst_rvalid", {31'b0, ReadValid}, 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
      chk("rst_odata", {24'b0, out_data}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      ld(A_STATUS, 32'h08);

      // overflow: five pushes into a 4-deep FIFO with no consumer
      for (int i = 0; i < 5; i++) st(A_DATA, 32'h41 + i);
      ld(A_STATUS, 32'h34);
      for (int i = 0; i < 4; i++) bq.push_back(8'h41 + 8'(i));
      drain();
      st(A_STATUS, 32'h20);
      ld(A_STATUS, 32'h08);

      // full FIFO with a simultaneous pop accepts the push
      for (int i = 0; i < 4; i++) st(A_DATA, 32'h61 + i);
      ld(A_STATUS, 32'h14);
      bq.push_back(8'h61);
      out_ready = 1'b1;
      st(A_DATA, 32'h55);
      out_ready = 1'b0;
      ld(A_STATUS, 32'h14);
      bq.push_back(8'h62); bq.push_back(8'h63); bq.push_back(8'h64); bq.push_back(8'h55);
      drain();

      // timer: back-to-back cycles, timing is exact
      st(A_RELOAD, 32'd3);
      st(A_CTRL, 32'd3);
      ld(A_COUNT, 32'd3);
      ld(A_COUNT, 32'd2);
      ld(A_COUNT, 32'd1);
      chk("irq_rise", {31'b0, irq}, 32'd1);
      ld(A_COUNT, 32'd3);
      ld(A_STATUS, 32'h48);
      st(A_STATUS, 32'h40);            // coincides with the next expiry
      chk("irq_set_wins", {31'b0, irq}, 32'd1);
      st(A_STATUS, 32'h40);
      chk("irq_fall", {31'b0, irq}, 32'd0);
      tick();
      st(A_RELOAD, 32'd5);             // same cycle as count 1->0
      chk("irq_reload_wins", {31'b0, irq}, 32'd0);
      ld(A_COUNT, 32'd5);
      ld(A_STATUS, 32'h08);
      st(A_CTRL, 32'd0);
      ld(A_CTRL, 32'd0);
      ld(A_RELOAD, 32'd5);
      ld(A_COUNT, 32'd2);

      // miss and unmapped
      st(32'h0000_0000, 32'h99);
      ld(A_STATUS, 32'h08);
      req = 1'b1; wr = 1'b0; Address = 32'h0000_0004;
      tick();
      req = 1'b0;
      chk("miss_rvalid", {31'b0, ReadValid}, 32'd0);
      chk("miss_rdata", ReadData, 32'd0);
      ld(A_UNMAP, 32'd0);
      ld(A_DATA, 32'd0);

      // reset with bytes queued
      st(A_DATA, 32'h11);
      st(A_DATA, 32'h22);
      chk("pre_rst_ovalid", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_rst_ovalid", {31'b0, out_valid}, 32'd0);
      ld(A_STATUS, 32'h08);
      ld(A_RELOAD, 32'd0);

      tick(); tick();
      chk("rq_drained", rq.size(), 32'd0);
      chk("bq_drained", bq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
